// File: rtl/rle_pkg.sv
// rle_pkg: shared defaults, width helpers and FSM encoding for the RLE line encoder
package rle_pkg;
  localparam int DEF_IMAGE_W  = 640;
  localparam int DEF_IMAGE_H  = 480;
  localparam int DEF_NUM_CH   = 3;
  localparam int DEF_MIN_SIZE = 60;
  localparam int DEF_MAX_GAP  = 2;
  typedef enum logic {IDLE, ACTIVE} state_t;
  function automatic int xw_of(input int w);
    return $clog2(w + 1);
  endfunction
  function automatic int yw_of(input int h);
    return h > 1 ? $clog2(h) : 1;
  endfunction
endpackage

// File: rtl/rle_line_encoder_if.sv
// rle_line_encoder_if: pixel stream in, per-line best-run results out
interface rle_line_encoder_if #(
  parameter int NUM_CH = 3,
  parameter int XW     = 10,
  parameter int YW     = 9
);
  logic                   enable;
  logic                   sop;
  logic [NUM_CH-1:0]      pixelin;
  logic                   out_valid;
  logic [NUM_CH*XW-1:0]   out_start;
  logic [NUM_CH*XW-1:0]   out_len;
  logic [NUM_CH-1:0]      out_found;
  logic [YW-1:0]          out_line;
  logic                   frame_end;
  modport master (output enable, sop, pixelin,
                  input  out_valid, out_start, out_len, out_found, out_line, frame_end);
  modport slave  (input  enable, sop, pixelin,
                  output out_valid, out_start, out_len, out_found, out_line, frame_end);
endinterface

// File: rtl/rle_run_tracker.sv
// rle_run_tracker: one channel's open-run, gap and best-run bookkeeping within a line
module rle_run_tracker import rle_pkg::*; #(
  parameter int XW      = 10,
  parameter int MAX_GAP = DEF_MAX_GAP
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          last,
  input  logic          pix,
  input  logic [XW-1:0] x,
  output logic [XW-1:0] res_start,
  output logic [XW-1:0] res_len
);
  localparam logic [XW-1:0] GAP_MAX = XW'(MAX_GAP);
  logic          open_q, open_d, open_c, open_n, gap_close, cand, better;
  logic [XW-1:0] start_q, start_d, start_c, start_n;
  logic [XW-1:0] len_q, len_d, len_c, len_n;
  logic [XW-1:0] gap_q, gap_d, gap_c, gap_n;
  logic [XW-1:0] bs_q, bs_d, bs_c, bl_q, bl_d, bl_c, cs, cl;
  always_comb begin
    open_c    = clr ? 1'b0 : open_q;
    start_c   = clr ? '0 : start_q;
    len_c     = clr ? '0 : len_q;
    gap_c     = clr ? '0 : gap_q;
    bs_c      = clr ? '0 : bs_q;
    bl_c      = clr ? '0 : bl_q;
    gap_close = !pix && open_c && gap_c >= GAP_MAX;
    open_n    = pix | (open_c & !gap_close);
    start_n   = (pix && !open_c) ? x : start_c;
    len_n     = !pix ? len_c : open_c ? len_c + gap_c + XW'(1) : XW'(1);
    gap_n     = (pix || gap_close || !open_c) ? '0 : gap_c + XW'(1);
    // a run still open on the last pixel closes in the same evaluation
    cand      = gap_close | (last & open_n);
    cs        = gap_close ? start_c : start_n;
    cl        = gap_close ? len_c : len_n;
    better    = cand && cl > bl_c;
    res_start = better ? cs : bs_c;
    res_len   = better ? cl : bl_c;
    open_d    = !en ? open_q  : !last & open_n;
    start_d   = !en ? start_q : last ? '0 : start_n;
    len_d     = !en ? len_q   : last ? '0 : len_n;
    gap_d     = !en ? gap_q   : last ? '0 : gap_n;
    bs_d      = !en ? bs_q    : last ? '0 : res_start;
    bl_d      = !en ? bl_q    : last ? '0 : res_len;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      open_q  <= 1'b0;
      start_q <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      bs_q    <= '0;
      bl_q    <= '0;
    end else begin
      open_q  <= open_d;
      start_q <= start_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      bs_q    <= bs_d;
      bl_q    <= bl_d;
    end
  end
endmodule

// File: rtl/rle_line_encoder.sv
// rle_line_encoder: per-line longest gap-tolerant run per mask channel, reported one cycle after each line
module rle_line_encoder import rle_pkg::*; #(
  parameter int IMAGE_W  = DEF_IMAGE_W,
  parameter int IMAGE_H  = DEF_IMAGE_H,
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int MIN_SIZE = DEF_MIN_SIZE,
  parameter int MAX_GAP  = DEF_MAX_GAP
) (
  input logic               CLK,
  input logic               reset,
  rle_line_encoder_if.slave bus
);
  localparam int XW = xw_of(IMAGE_W);
  localparam int YW = yw_of(IMAGE_H);
  localparam logic [XW-1:0] X_LAST  = XW'(IMAGE_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMAGE_H - 1);
  localparam logic [XW-1:0] MIN_LEN = XW'(MIN_SIZE);
  state_t               state_q, state_d;
  logic [XW-1:0]        x_q, x_d, xe;
  logic [YW-1:0]        y_q, y_d, ye;
  logic                 clr, acc, last;
  logic [XW-1:0]        rs [NUM_CH];
  logic [XW-1:0]        rl [NUM_CH];
  logic                 out_valid_q, out_valid_d, frame_end_q, frame_end_d;
  logic [NUM_CH*XW-1:0] out_start_q, out_start_d, out_len_q, out_len_d;
  logic [NUM_CH-1:0]    out_found_q, out_found_d;
  logic [YW-1:0]        out_line_q, out_line_d;
  assign clr  = bus.enable & bus.sop;
  assign acc  = clr | (bus.enable & (state_q == ACTIVE));
  assign xe   = clr ? '0 : x_q;
  assign ye   = clr ? '0 : y_q;
  assign last = acc & (xe == X_LAST);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rle_run_tracker #(.XW(XW), .MAX_GAP(MAX_GAP)) u_trk (
      .clk(CLK), .rst(reset), .en(acc), .clr(clr), .last(last),
      .pix(bus.pixelin[c]), .x(xe), .res_start(rs[c]), .res_len(rl[c])
    );
  end
  always_comb begin
    state_d     = !acc ? state_q : (last && ye == Y_LAST) ? IDLE : ACTIVE;
    x_d         = !acc ? x_q : last ? '0 : xe + XW'(1);
    y_d         = !acc ? y_q : !last ? ye : (ye == Y_LAST) ? '0 : ye + YW'(1);
    out_valid_d = last;
    frame_end_d = last && ye == Y_LAST;
    out_line_d  = last ? ye : out_line_q;
    out_start_d = out_start_q;
    out_len_d   = out_len_q;
    out_found_d = out_found_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (last) begin
        out_found_d[c]           = rl[c] >= MIN_LEN;
        out_start_d[c*XW +: XW]  = (rl[c] >= MIN_LEN) ? rs[c] : '0;
        out_len_d[c*XW +: XW]    = (rl[c] >= MIN_LEN) ? rl[c] : '0;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      frame_end_q <= 1'b0;
      out_start_q <= '0;
      out_len_q   <= '0;
      out_found_q <= '0;
      out_line_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      frame_end_q <= frame_end_d;
      out_start_q <= out_start_d;
      out_len_q   <= out_len_d;
      out_found_q <= out_found_d;
      out_line_q  <= out_line_d;
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.frame_end = frame_end_q;
  assign bus.out_start = out_start_q;
  assign bus.out_len   = out_len_q;
  assign bus.out_found = out_found_q;
  assign bus.out_line  = out_line_q;
endmodule
